// File: rtl/wb_host_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle out,
// one response back, with running counts of acked and timed-out transfers.
module wb_host_initiator #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [31:0]      cmd_dat,
  input  logic [3:0]       cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Timer holds the number of completed no-ack cycles; the TIMEOUT-th one aborts.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] timer;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      timer     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      busy      <= 1'b0;
      xfer_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cmd_ready <= 1'b0;
            timer     <= '0;
            busy      <= 1'b1;
            state     <= BUS;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        BUS: begin
          // An ack on the final allowed cycle still counts as a normal completion.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            xfer_cnt  <= xfer_cnt + CNT_W'(1);
            state     <= RESP;
          end else if (timer == TIMER_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            err_cnt   <= err_cnt + CNT_W'(1);
            state     <= RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_initiator.sv
// Self-checking bench for wb_host_initiator: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_wb_host_initiator;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_we = 1'b0;
  logic [31:0]      cmd_adr = '0;
  logic [31:0]      cmd_dat = '0;
  logic [3:0]       cmd_sel = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [31:0]      rsp_dat;
  logic             rsp_err;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o;
  logic [31:0]      wbm_dat_o;
  logic             wbm_ack_i;
  logic [31:0]      wbm_dat_i;
  logic             busy;
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  wb_host_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt),
    .err_cnt   (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave: acks after ack_delay wait states (negative = never); data only valid with ack.
  int          ack_delay  = -1;
  logic [31:0] slave_data = '0;
  int          stb_idx    = 0;
  logic        slave_ack  = 1'b0;
  logic        stray_ack  = 1'b0;

  assign wbm_ack_i = slave_ack | stray_ack;
  assign wbm_dat_i = slave_ack ? slave_data : 32'hFFFF_0000;

  always @(negedge clk) begin
    if (wbm_cyc_o && wbm_stb_o) begin
      slave_ack = (ack_delay >= 0) && (stb_idx == ack_delay);
      stb_idx++;
    end else begin
      slave_ack = 1'b0;
      stb_idx   = 0;
    end
  end

  // Transaction model: a bus phase lasts min(waits+1, TIMEOUT) cycles after acceptance.
  logic             m_ready = 0, m_rsp_valid = 0, m_in_flight = 0, m_cyc = 0;
  logic             m_timed_out = 0, m_we = 0, m_err = 0;
  logic [31:0]      m_adr = '0, m_dat = '0, m_rsp_dat = '0;
  logic [3:0]       m_sel = '0;
  logic [CNT_W-1:0] m_xfer = '0, m_errc = '0;
  int               edge_n = 0, acc_edge = 0, bus_len = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0; m_rsp_valid = 0; m_in_flight = 0; m_cyc = 0;
      m_xfer = '0; m_errc = '0; edge_n = 0;
    end else begin
      edge_n++;
      if (m_rsp_valid) begin
        if (rsp_ready) begin
          m_rsp_valid = 0;
          m_ready     = 1;
        end
      end else if (m_in_flight) begin
        if (edge_n == acc_edge + bus_len) begin
          m_cyc       = 0;
          m_in_flight = 0;
          m_rsp_valid = 1;
          m_err       = m_timed_out;
          m_rsp_dat   = (m_timed_out || m_we) ? 32'h0 : slave_data;
          if (m_timed_out) m_errc = m_errc + 1'b1;
          else             m_xfer = m_xfer + 1'b1;
        end
      end else if (m_ready && cmd_valid) begin
        m_ready     = 0;
        m_in_flight = 1;
        m_cyc       = 1;
        acc_edge    = edge_n;
        m_timed_out = !(ack_delay >= 0 && ack_delay < TIMEOUT);
        bus_len     = m_timed_out ? TIMEOUT : ack_delay + 1;
        m_we = cmd_we; m_adr = cmd_adr; m_dat = cmd_dat; m_sel = cmd_sel;
      end else begin
        m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst cmd_ready", cmd_ready, 0);
      checkOutput("rst cyc", wbm_cyc_o, 0);
      checkOutput("rst stb", wbm_stb_o, 0);
      checkOutput("rst rsp_valid", rsp_valid, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst adr", wbm_adr_o, 0);
      checkOutput("rst rsp_dat", rsp_dat, 0);
      checkOutput("rst xfer_cnt", 32'(xfer_cnt), 0);
      checkOutput("rst err_cnt", 32'(err_cnt), 0);
    end else begin
      checkOutput("cmd_ready", cmd_ready, m_ready);
      checkOutput("cyc", wbm_cyc_o, m_cyc);
      checkOutput("stb", wbm_stb_o, m_cyc);
      checkOutput("rsp_valid", rsp_valid, m_rsp_valid);
      checkOutput("busy", busy, m_in_flight | m_rsp_valid);
      checkOutput("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
      checkOutput("err_cnt", 32'(err_cnt), 32'(m_errc));
      if (m_cyc) begin
        checkOutput("wbm_we", wbm_we_o, m_we);
        checkOutput("wbm_adr", wbm_adr_o, m_adr);
        checkOutput("wbm_dat", wbm_dat_o, m_dat);
        checkOutput("wbm_sel", wbm_sel_o, m_sel);
      end
      if (m_rsp_valid) begin
        checkOutput("rsp_dat", rsp_dat, m_rsp_dat);
        checkOutput("rsp_err", rsp_err, m_err);
      end
    end
  end

  // Bus-cycle monitor: length of the last cyc pulse and what was presented in it.
  int          cyc_run = 0, last_cyc_len = 0, cyc_starts = 0;
  logic [31:0] cap_adr = '0, cap_dat = '0;
  logic [3:0]  cap_sel = '0;
  logic        we_seen = 1'b0;

  always @(negedge clk) begin
    if (wbm_cyc_o) begin
      if (cyc_run == 0) begin
        cyc_starts++;
        cap_adr = wbm_adr_o; cap_dat = wbm_dat_o; cap_sel = wbm_sel_o;
      end
      if (wbm_we_o) we_seen = 1'b1;
      cyc_run++;
    end else if (cyc_run > 0) begin
      last_cyc_len = cyc_run;
      cyc_run      = 0;
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input int delay, input logic [31:0] rdata);
    bit accepted = 0;
    ack_delay  = delay;
    slave_data = rdata;
    we_seen    = 1'b0;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin
        accepted = 1;
        break;
      end
      nextCycle();
    end
    if (!accepted) checkOutput("accept timeout", 0, 1);
    nextCycle();
    cmd_valid = 1'b0;
  endtask

  task automatic waitResponse(output logic [31:0] dat, output logic err);
    bit seen = 0;
    dat = '0;
    err = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (rsp_valid) begin
        seen = 1;
        break;
      end
      nextCycle();
    end
    if (!seen) checkOutput("response timeout", 0, 1);
    dat = rsp_dat;
    err = rsp_err;
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] d;
  logic        e;
  int          start;

  initial begin
    repeat (2) nextCycle();
    checkOutput("reset cmd_ready", cmd_ready, 0);
    checkOutput("reset cyc", wbm_cyc_o, 0);
    checkOutput("reset xfer_cnt", 32'(xfer_cnt), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    nextCycle();
    checkOutput("ready after reset", cmd_ready, 1);

    stray_ack = 1'b1;
    nextCycle();
    stray_ack = 1'b0;
    nextCycle();
    checkOutput("idle stray busy", busy, 0);
    checkOutput("idle stray rsp_valid", rsp_valid, 0);

    $display("[TB] zero-wait write");
    applyStimulus(1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF, 0, 32'h0);
    waitResponse(d, e);
    checkOutput("wr len", last_cyc_len, 1);
    checkOutput("wr adr", cap_adr, 32'h3000_0000);
    checkOutput("wr dat", cap_dat, 32'hA5A5_1234);
    checkOutput("wr sel", 32'(cap_sel), 32'hF);
    checkOutput("wr rsp_dat", d, 0);
    checkOutput("wr rsp_err", e, 0);
    checkOutput("wr xfer_cnt", 32'(xfer_cnt), 1);

    $display("[TB] read with 3 wait states");
    applyStimulus(1'b0, 32'h3000_0004, 32'h5555_AAAA, 4'hF, 3, 32'hDEAD_BEEF);
    waitResponse(d, e);
    checkOutput("rd len", last_cyc_len, 4);
    checkOutput("rd rsp_dat", d, 32'hDEAD_BEEF);
    checkOutput("rd rsp_err", e, 0);
    checkOutput("rd we seen", we_seen, 0);
    checkOutput("rd xfer_cnt", 32'(xfer_cnt), 2);

    $display("[TB] timeout");
    applyStimulus(1'b0, 32'h3000_0008, 32'h0, 4'hF, -1, 32'h7777_7777);
    waitResponse(d, e);
    checkOutput("to len", last_cyc_len, 16);
    checkOutput("to rsp_dat", d, 0);
    checkOutput("to rsp_err", e, 1);
    checkOutput("to err_cnt", 32'(err_cnt), 1);
    checkOutput("to xfer_cnt", 32'(xfer_cnt), 2);

    $display("[TB] ack on last allowed cycle");
    applyStimulus(1'b0, 32'h3000_000C, 32'h0, 4'h1, 15, 32'h1234_5678);
    waitResponse(d, e);
    checkOutput("last len", last_cyc_len, 16);
    checkOutput("last rsp_dat", d, 32'h1234_5678);
    checkOutput("last rsp_err", e, 0);
    checkOutput("last err_cnt", 32'(err_cnt), 1);
    checkOutput("last xfer_cnt", 32'(xfer_cnt), 3);

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 32'h3000_0010, 32'h1111_2222, 4'h3, 0, 32'h0);
    waitResponse(d, e);
    ack_delay  = 1;
    slave_data = 32'hCAFE_F00D;
    cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    start = cyc_starts;
    for (int i = 0; i < 10; i++) begin
      stray_ack = (i % 2) == 0;
      nextCycle();
      checkOutput("bp rsp_valid", rsp_valid, 1);
      checkOutput("bp rsp_dat", rsp_dat, 0);
      checkOutput("bp cmd_ready", cmd_ready, 0);
    end
    stray_ack = 1'b0;
    checkOutput("bp no bus cycle", cyc_starts, start);
    checkOutput("bp xfer_cnt", 32'(xfer_cnt), 4);
    rsp_ready = 1'b1;
    nextCycle();
    nextCycle();
    cmd_valid = 1'b0;
    waitResponse(d, e);
    checkOutput("bp next rsp_dat", d, 32'hCAFE_F00D);
    checkOutput("bp next len", last_cyc_len, 2);
    checkOutput("bp next starts", cyc_starts, start + 1);
    checkOutput("bp next xfer_cnt", 32'(xfer_cnt), 5);

    $display("[TB] reset during bus phase");
    applyStimulus(1'b0, 32'h3000_0030, 32'h0, 4'hF, -1, 32'h0);
    repeat (5) nextCycle();
    checkOutput("pre-reset cyc", wbm_cyc_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async cyc", wbm_cyc_o, 0);
    checkOutput("async stb", wbm_stb_o, 0);
    checkOutput("async busy", busy, 0);
    checkOutput("async adr", wbm_adr_o, 0);
    checkOutput("async err_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    nextCycle();
    checkOutput("post-reset cmd_ready", cmd_ready, 1);
    checkOutput("post-reset rsp_valid", rsp_valid, 0);
    applyStimulus(1'b0, 32'h3000_0040, 32'h0, 4'hF, 2, 32'h0BAD_CAFE);
    waitResponse(d, e);
    checkOutput("post-reset rsp_dat", d, 32'h0BAD_CAFE);
    checkOutput("post-reset rsp_err", e, 0);
    checkOutput("post-reset len", last_cyc_len, 3);
    checkOutput("post-reset xfer_cnt", 32'(xfer_cnt), 1);
    checkOutput("post-reset err_cnt", 32'(err_cnt), 0);

    repeat (3) nextCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
